gte_cop2_ctrl: RTL and testbench

- Sequences the GTE engine on behalf of the CPU COP2 interface: issues GTE commands, serialises MTC2/CTC2 register writes and MFC2/CFC2 reads against engine execution, and stalls the CPU when ordering requires it.
- Holds one pending command, so the CPU can post a second COP2 command while the first executes.
- Runs a watchdog on engine busy time.
- Sits between the CPU coprocessor port and the GTE engine's regID/WritReg/dataIn/dataOut/Instruction/run/executing port.

---
 rtl/gte_ctrl_pkg.sv | 27 ++
 rtl/gte_busy_watchdog.sv | 57 +++++
 rtl/gte_cop2_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_gte_cop2_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gte_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : gte_ctrl_pkg
//  Purpose  : Shared types and widths for the GTE COP2 sequencer.
//             - e_cop2_state : sequencer state encoding
//             - c_CMD_W      : COP2 command word width
//             - c_REG_IDX_W  : GTE register index width (data 0-31, ctrl 32-63)
//  Revision : 1.0 - initial release
// ============================================================================
package gte_ctrl_pkg;

    localparam int c_CMD_W     = 25;
    localparam int c_REG_IDX_W = 6;

    // IDLE   : no command in flight, register ops may be served
    // LAUNCH : run pulse, pending word handed to the engine
    // SETTLE : engine executing flag is not yet valid
    // BUSY   : wait for the engine to drop executing
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        SETTLE = 2'd2,
        BUSY   = 2'd3
    } e_cop2_state;

endpackage : gte_ctrl_pkg
`default_nettype wire

// File: rtl/gte_busy_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : gte_busy_watchdog
//  Purpose  : Counts consecutive engine-busy cycles and raises a sticky error
//             once the count reaches WDOG_CYCLES. Purely observational.
//  Ports    : i_clk    - clock
//             i_nRst   - synchronous reset, active-low
//             i_busy   - engine executing flag
//             i_clr    - clears the sticky error (a same-cycle set wins)
//             o_err    - sticky watchdog error
//  Revision : 1.0 - initial release
// ============================================================================
module gte_busy_watchdog #(
    parameter int                WDOG_W      = 8,
    parameter logic [WDOG_W-1:0] WDOG_CYCLES = 8'd255
) (
    input  logic i_clk,
    input  logic i_nRst,
    input  logic i_busy,
    input  logic i_clr,
    output logic o_err
);

    // Count value that, when seen with busy still high, completes the limit.
    localparam logic [WDOG_W-1:0] c_LAST = WDOG_CYCLES - WDOG_W'(1);

    logic [WDOG_W-1:0] r_cnt;
    logic              r_err;
    logic              w_reach;

    // The flag sets only on the cycle the limit is reached; while the engine
    // stays stuck with a saturated counter a clear is therefore honoured.
    assign w_reach = i_busy && (r_cnt == c_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (!i_busy) begin
                r_cnt <= '0;
            end else if (r_cnt != WDOG_CYCLES) begin
                r_cnt <= r_cnt + WDOG_W'(1);
            end

            if (w_reach) begin
                r_err <= 1'b1;
            end else if (i_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_err = r_err;

endmodule : gte_busy_watchdog
`default_nettype wire

// File: rtl/gte_cop2_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : gte_cop2_ctrl
//  Purpose  : Sequences the GTE engine for the CPU COP2 port. Launches
//             commands through a one-deep pending slot, orders register
//             reads/writes behind command execution and stalls the CPU when
//             a request cannot be taken. Includes a busy-time watchdog.
//  Ports    : i_clk, i_nRst          - clock, synchronous active-low reset
//             i_cmdValid/i_cmdWord   - CPU COP2 command
//             i_regWr/i_regRd        - CPU register write / read request
//             i_regIdx/i_wdata       - register index and write data
//             o_rdata/o_rdValid      - registered read data and its pulse
//             o_stall                - CPU must hold its current request
//             o_gteRegID/o_gteWrite/o_gteDataOut/i_gteDataIn
//                                    - engine register port
//             o_gteInstr/o_gteRun/i_gteExecuting
//                                    - engine command port
//             o_wdogErr/i_wdogClr    - sticky watchdog error and its clear
//  Revision : 1.0 - initial release
// ============================================================================
module gte_cop2_ctrl
    import gte_ctrl_pkg::*;
#(
    parameter int                WDOG_W      = 8,
    parameter logic [WDOG_W-1:0] WDOG_CYCLES = 8'd255
) (
    input  logic                   i_clk,
    input  logic                   i_nRst,
    input  logic                   i_cmdValid,
    input  logic [c_CMD_W-1:0]     i_cmdWord,
    input  logic                   i_regWr,
    input  logic                   i_regRd,
    input  logic [c_REG_IDX_W-1:0] i_regIdx,
    input  logic [31:0]            i_wdata,
    output logic [31:0]            o_rdata,
    output logic                   o_rdValid,
    output logic                   o_stall,
    output logic [c_REG_IDX_W-1:0] o_gteRegID,
    output logic                   o_gteWrite,
    output logic [31:0]            o_gteDataOut,
    input  logic [31:0]            i_gteDataIn,
    output logic [c_CMD_W-1:0]     o_gteInstr,
    output logic                   o_gteRun,
    input  logic                   i_gteExecuting,
    output logic                   o_wdogErr,
    input  logic                   i_wdogClr
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    e_cop2_state        r_state;
    e_cop2_state        w_stateNext;

    logic               r_pendValid;
    logic [c_CMD_W-1:0] r_pendWord;
    // Last launched word; keeps o_gteInstr stable while the engine executes.
    logic [c_CMD_W-1:0] r_lastInstr;

    logic [31:0]        r_rdata;
    logic               r_rdValid;

    // ------------------------------------------------------------------------
    // Acceptance decisions. Everything is gated by i_nRst so that nothing is
    // taken, launched or written while reset is asserted.
    // ------------------------------------------------------------------------
    logic w_drain;
    logic w_cmdAcc;
    logic w_regOk;
    logic w_wrAcc;
    logic w_rdAcc;

    // The pending slot is always full in LAUNCH and empties at its end, so a
    // new command can take the slot in the same cycle.
    assign w_drain  = (r_state == LAUNCH);
    assign w_cmdAcc = i_nRst && i_cmdValid && (!r_pendValid || w_drain);

    // Register traffic only when nothing is queued or running, which keeps
    // reads and writes ordered after every earlier command. A simultaneous
    // command takes priority over the register op.
    assign w_regOk  = i_nRst && (r_state == IDLE) && !r_pendValid && !i_cmdValid;
    assign w_wrAcc  = i_regWr && w_regOk;
    // A write and a read together is illegal; the write goes first.
    assign w_rdAcc  = i_regRd && !i_regWr && w_regOk;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and engine/CPU handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_stateNext  = r_state;
        o_gteRun     = 1'b0;
        o_gteInstr   = '0;
        o_gteWrite   = 1'b0;
        o_gteRegID   = '0;
        o_gteDataOut = '0;
        o_stall      = 1'b0;

        case (r_state)
            IDLE: begin
                // A word left pending while the engine was still busy is
                // launched first; otherwise a freshly accepted command goes.
                if ((r_pendValid && !i_gteExecuting) || w_cmdAcc) begin
                    w_stateNext = LAUNCH;
                end
            end
            LAUNCH: begin
                w_stateNext = SETTLE;
            end
            SETTLE: begin
                // Engine raises executing one cycle after run; skip that
                // cycle so BUSY does not see a stale low.
                w_stateNext = BUSY;
            end
            BUSY: begin
                if (!i_gteExecuting) begin
                    w_stateNext = r_pendValid ? LAUNCH : IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase

        if (i_nRst) begin
            o_gteRun   = w_drain;
            o_gteInstr = w_drain ? r_pendWord : r_lastInstr;
            o_gteWrite = w_wrAcc;
            if (w_wrAcc || w_rdAcc) begin
                o_gteRegID = i_regIdx;
            end
            if (w_wrAcc) begin
                o_gteDataOut = i_wdata;
            end
            o_stall = (i_cmdValid && !w_cmdAcc)
                   || (i_regWr    && !w_wrAcc)
                   || (i_regRd    && !w_rdAcc);
        end
    end

    // ------------------------------------------------------------------------
    // Pending command slot
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            r_pendValid <= 1'b0;
            r_pendWord  <= '0;
            r_lastInstr <= '0;
        end else begin
            if (w_cmdAcc) begin
                r_pendValid <= 1'b1;
                r_pendWord  <= i_cmdWord;
            end else if (w_drain) begin
                r_pendValid <= 1'b0;
            end

            if (w_drain) begin
                r_lastInstr <= r_pendWord;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read return: engine data is combinational from o_gteRegID, so it is
    // captured at the end of the accept cycle and presented one cycle later.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            r_rdata   <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= w_rdAcc;
            if (w_rdAcc) begin
                r_rdata <= i_gteDataIn;
            end
        end
    end

    assign o_rdata   = r_rdata;
    assign o_rdValid = r_rdValid;

    // ------------------------------------------------------------------------
    // Busy-time watchdog
    // ------------------------------------------------------------------------
    gte_busy_watchdog #(
        .WDOG_W      (WDOG_W),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .i_clk  (i_clk),
        .i_nRst (i_nRst),
        .i_busy (i_gteExecuting),
        .i_clr  (i_wdogClr),
        .o_err  (o_wdogErr)
    );

endmodule : gte_cop2_ctrl
`default_nettype wire

// File: tb/tb_gte_cop2_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gte_cop2_ctrl
//  Purpose  : Self-checking bench for gte_cop2_ctrl with a behavioural
//             controller model, a small GTE engine model and random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gte_cop2_ctrl;

    localparam int WD = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        nRst, cmdValid, regWr, regRd, wdogClr;
    logic [24:0] cmdWord;
    logic [5:0]  regIdx;
    logic [31:0] wdata;

    logic [31:0] o_rdata, o_gteDataOut, gteDataIn;
    logic        o_rdValid, o_stall, o_gteWrite, o_gteRun, o_wdogErr;
    logic [5:0]  o_gteRegID;
    logic [24:0] o_gteInstr;

    // Engine model state
    logic [31:0] eng_regs [0:63];
    logic        eng_exec;
    int          eng_left;
    int          eng_dur;
    logic [24:0] eng_instr;
    bit          rnd_mode;

    assign gteDataIn = eng_regs[o_gteRegID];

    gte_cop2_ctrl #(.WDOG_W(8), .WDOG_CYCLES(8'd8)) dut (
        .i_clk(clk), .i_nRst(nRst), .i_cmdValid(cmdValid), .i_cmdWord(cmdWord),
        .i_regWr(regWr), .i_regRd(regRd), .i_regIdx(regIdx), .i_wdata(wdata),
        .o_rdata(o_rdata), .o_rdValid(o_rdValid), .o_stall(o_stall),
        .o_gteRegID(o_gteRegID), .o_gteWrite(o_gteWrite), .o_gteDataOut(o_gteDataOut),
        .i_gteDataIn(gteDataIn), .o_gteInstr(o_gteInstr), .o_gteRun(o_gteRun),
        .i_gteExecuting(eng_exec), .o_wdogErr(o_wdogErr), .i_wdogClr(wdogClr)
    );

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural controller model.
    // m_age: -1 nothing in flight, 0 = run cycle, 1 = settle cycle,
    //        2 = waiting for the engine to finish.
    // m_q  : commands accepted but not yet launched (FIFO).
    // ------------------------------------------------------------------------
    int          m_age;
    logic [24:0] m_q[$];
    logic [24:0] m_last;
    logic [31:0] m_rdata;
    bit          m_rdv;
    int          m_wd;
    bit          m_err;

    bit          p_cmdAcc, p_wr, p_rd, p_stall, p_run;
    logic [24:0] p_instr;
    logic [5:0]  p_regID;
    logic [31:0] p_dout;
    bit          a_cmd, a_wr, a_rd;

    function automatic void model_reset();
        m_age = -1; m_q.delete(); m_last = '0; m_rdata = '0; m_rdv = 0; m_wd = 0; m_err = 0;
    endfunction

    function automatic void predict();
        bit idle, drain, empty, reg_ok;
        idle  = (m_age < 0);
        drain = (m_age == 0);
        empty = (m_q.size() == 0);
        p_cmdAcc = cmdValid && (empty || drain);
        reg_ok   = idle && empty && !cmdValid;
        p_wr     = regWr && reg_ok;
        p_rd     = regRd && !regWr && reg_ok;
        p_stall  = (cmdValid && !p_cmdAcc) || (regWr && !p_wr) || (regRd && !p_rd);
        p_run    = drain;
        p_instr  = (drain && !empty) ? m_q[0] : m_last;
        p_regID  = (p_wr || p_rd) ? regIdx : 6'd0;
        p_dout   = p_wr ? wdata : 32'd0;
        if (!nRst) begin
            p_cmdAcc = 0; p_wr = 0; p_rd = 0; p_stall = 0; p_run = 0;
            p_instr = '0; p_regID = '0; p_dout = '0;
        end
    endfunction

    // Clock-edge update of model and engine, evaluated on pre-edge values.
    function automatic void advance();
        bit e, was_empty;
        int nage;
        predict();
        a_cmd = p_cmdAcc; a_wr = p_wr; a_rd = p_rd;
        if (!nRst) begin
            model_reset();
            eng_left = 0;
            eng_exec = 1'b0;
            return;
        end
        e = eng_exec;
        was_empty = (m_q.size() == 0);

        m_rdv = p_rd;
        if (p_rd) m_rdata = eng_regs[regIdx];

        if (e && m_wd == WD - 1) m_err = 1;
        else if (wdogClr) m_err = 0;
        m_wd = e ? ((m_wd < WD) ? m_wd + 1 : WD) : 0;

        nage = m_age;
        if (m_age < 0) nage = ((!was_empty && !e) || p_cmdAcc) ? 0 : -1;
        else if (m_age == 0) nage = 1;
        else if (m_age == 1) nage = 2;
        else if (!e) nage = was_empty ? -1 : 0;
        m_age = nage;
        if (p_run) m_last = m_q.pop_front();
        if (p_cmdAcc) m_q.push_back(cmdWord);

        // Engine: result of a command lands in reg 25 when it completes.
        if (p_run) begin
            eng_left  = rnd_mode ? int'($urandom_range(1, 12)) : eng_dur;
            eng_instr = p_instr;
        end else if (eng_left > 0) begin
            eng_left--;
            if (eng_left == 0) eng_regs[25] = 32'h0000_1233 + {7'd0, eng_instr};
        end
        if (p_wr) eng_regs[regIdx] = wdata;
        eng_exec = (eng_left > 0);
    endfunction

    // ------------------------------------------------------------------------
    // Compare process: every cycle, between the input change and the edge.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        #1;
        if (cmp_en) begin
            predict();
            chk("stall",   32'(o_stall),      32'(p_stall));
            chk("run",     32'(o_gteRun),     32'(p_run));
            chk("instr",   32'(o_gteInstr),   32'(p_instr));
            chk("write",   32'(o_gteWrite),   32'(p_wr));
            chk("regid",   32'(o_gteRegID),   32'(p_regID));
            chk("dataout", o_gteDataOut,      p_dout);
            chk("rdvalid", 32'(o_rdValid),    32'(m_rdv));
            chk("rdata",   o_rdata,           m_rdata);
            chk("wdogerr", 32'(o_wdogErr),    32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        advance();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int n;
        for (int i = 0; i < 64; i++) eng_regs[i] = 32'd0;
        eng_exec = 0; eng_left = 0; eng_dur = 14; eng_instr = '0; rnd_mode = 0;
        model_reset();
        a_cmd = 0; a_wr = 0; a_rd = 0;
        nRst = 0; cmdValid = 1; cmdWord = 25'h0000155; regWr = 0; regRd = 0;
        regIdx = 0; wdata = 0; wdogClr = 0;
        cmp_en = 1;
        tick();

        // Reset held with a command offered
        repeat (3) begin
            #2;
            chk("rst_run",   32'(o_gteRun),   32'd0);
            chk("rst_stall", 32'(o_stall),    32'd0);
            chk("rst_wdog",  32'(o_wdogErr),  32'd0);
            chk("rst_rdv",   32'(o_rdValid),  32'd0);
            tick();
        end
        nRst = 1; cmdValid = 0; regWr = 1; regIdx = 6'd2; wdata = 32'd7;
        #2;
        chk("rst_idle_nostall", 32'(o_stall),    32'd0);
        chk("rst_idle_write",   32'(o_gteWrite), 32'd1);
        tick();
        regWr = 0;
        tick();

        // Single command, then an immediate read of its result register
        eng_dur = 14; cmdValid = 1; cmdWord = 25'h0000001;
        #2; chk("cmd_nostall", 32'(o_stall), 32'd0);
        tick();
        cmdValid = 0; regRd = 1; regIdx = 6'd25;
        #2;
        chk("cmd_run",   32'(o_gteRun),   32'd1);
        chk("cmd_instr", 32'(o_gteInstr), 32'h0000001);
        n = 0;
        for (int k = 0; k < 100 && o_stall; k++) begin n++; tick(); #2; end
        chk("ord_stall_cycles", 32'(n), 32'd16);
        tick();
        regRd = 0;
        #2;
        chk("ord_rdvalid", 32'(o_rdValid), 32'd1);
        chk("ord_rdata",   o_rdata,        32'h0000_1234);
        wdogClr = 1; tick(); wdogClr = 0; tick();

        // Back-to-back commands
        eng_dur = 5; cmdValid = 1; cmdWord = 25'h0A00012;
        tick();
        cmdValid = 0; tick();
        cmdValid = 1; cmdWord = 25'h1B00013;
        #2; chk("b2b_B_nostall", 32'(o_stall), 32'd0);
        tick();
        cmdWord = 25'h0C00014;
        #2;
        n = 0;
        for (int k = 0; k < 100 && o_stall; k++) begin n++; tick(); #2; end
        chk("b2b_C_stall_cycles", 32'(n), 32'd5);
        chk("b2b_B_run",   32'(o_gteRun),   32'd1);
        chk("b2b_B_instr", 32'(o_gteInstr), 32'h1B00013);
        tick();
        cmdValid = 0;
        repeat (30) tick();

        // Write path, then read back
        regWr = 1; regIdx = 6'd0; wdata = 32'hDEADBEEF;
        #2;
        chk("wr_strobe", 32'(o_gteWrite),   32'd1);
        chk("wr_regid",  32'(o_gteRegID),   32'd0);
        chk("wr_data",   o_gteDataOut,      32'hDEADBEEF);
        chk("wr_nostall",32'(o_stall),      32'd0);
        tick();
        regWr = 0; regRd = 1;
        tick();
        regRd = 0;
        #2; chk("wr_readback", o_rdata, 32'hDEADBEEF);
        tick();

        // Write and read together: write first, read next cycle
        regWr = 1; regRd = 1; regIdx = 6'd3; wdata = 32'h0000_0005;
        #2;
        chk("wrrd_write", 32'(o_gteWrite), 32'd1);
        chk("wrrd_stall", 32'(o_stall),    32'd1);
        tick();
        regWr = 0;
        #2; chk("wrrd_rd_nostall", 32'(o_stall), 32'd0);
        tick();
        regRd = 0;
        #2; chk("wrrd_rdata", o_rdata, 32'h0000_0005);
        tick();

        // Watchdog on a stuck engine
        eng_dur = 1000; cmdValid = 1; cmdWord = 25'h0000030;
        tick();
        cmdValid = 0;
        #2;
        n = 0;
        for (int k = 0; k < 40 && !o_wdogErr; k++) begin
            if (eng_exec) n++;
            tick(); #2;
        end
        chk("wdog_busy_cycles", 32'(n), 32'd8);
        cmdValid = 1; cmdWord = 25'h0000031;   // lands in the pending slot
        tick();
        cmdValid = 0; wdogClr = 1;
        tick();
        wdogClr = 0;
        #2; chk("wdog_cleared", 32'(o_wdogErr), 32'd0);
        // Reset mid-BUSY with a pending command
        nRst = 0; cmdValid = 1; cmdWord = 25'h0000032;
        tick(); tick();
        nRst = 1; cmdValid = 0; regRd = 1; regIdx = 6'd25;
        #2;
        chk("midrst_idle", 32'(o_stall),  32'd0);
        chk("midrst_norun",32'(o_gteRun), 32'd0);
        tick();
        regRd = 0;
        n = 0;
        repeat (5) begin #2; if (o_gteRun) n++; tick(); end
        chk("midrst_no_launch", 32'(n), 32'd0);

        // Set and clear in the same cycle: set wins for one cycle
        eng_dur = 12; wdogClr = 1; cmdValid = 1; cmdWord = 25'h0000040;
        tick();
        cmdValid = 0;
        n = 0;
        for (int k = 0; k < 25; k++) begin #2; if (o_wdogErr) n++; tick(); end
        chk("wdog_set_wins_cycles", 32'(n), 32'd1);
        wdogClr = 0;
        repeat (5) tick();

        // Randomised traffic against the model
        rnd_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            nRst = ($urandom_range(0, 299) != 0);
            wdogClr = ($urandom_range(0, 15) == 0);
            if (!(cmdValid && !a_cmd)) begin
                cmdValid = ($urandom_range(0, 3) == 0);
                cmdWord  = 25'($urandom);
            end
            if (regWr && a_wr) regWr = 0;
            if (regRd && a_rd) regRd = 0;
            if (!regWr && !regRd) begin
                regWr  = ($urandom_range(0, 5) == 0);
                regRd  = ($urandom_range(0, 4) == 0);
                regIdx = ($urandom_range(0, 1) == 1) ? 6'd25 : 6'($urandom);
                wdata  = $urandom;
            end
            tick();
        end
        nRst = 1; cmdValid = 0; regWr = 0; regRd = 0; wdogClr = 0;
        repeat (3) tick();
        cmp_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_gte_cop2_ctrl
`default_nettype wire
